// File: rtl/acumulador_pkg.sv
// Shared types for the acumulador signed accumulator.
// Holds the default width, FSM state type and flag bundle.
package acumulador_pkg;

  localparam int NUM_BITS_DEF = 8;
  localparam int CNT_BITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic Z;
    logic N;
    logic P;
    logic V;
  } flags_t;

  localparam flags_t FLAGS_CLR = '{Z: 1'b1, N: 1'b0, P: 1'b1, V: 1'b0};

endpackage

// File: rtl/acumulador_if.sv
// Control, operand and result handshake bundle for acumulador.
// master drives requests/operands; slave is the accumulator.
interface acumulador_if
  import acumulador_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) ();

  logic                       start;
  logic [CNT_BITS-1:0]        count;
  logic                       busy;
  logic                       in_valid;
  logic signed [NUM_BITS-1:0] in_data;
  logic                       in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [NUM_BITS-1:0] S;
  logic                       Z;
  logic                       N;
  logic                       P;
  logic                       V;

  modport master (
    output start, count, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, S, Z, N, P, V
  );

  modport slave (
    input  start, count, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, S, Z, N, P, V
  );

endinterface

// File: rtl/acc_somador.sv
// Combinational signed adder: raw NUM_BITS sum plus
// two's-complement overflow detection.
module acc_somador #(
  parameter int NUM_BITS = 8
) (
  input  logic signed [NUM_BITS-1:0] a_i,
  input  logic signed [NUM_BITS-1:0] b_i,
  output logic signed [NUM_BITS-1:0] sum_o,
  output logic                       ovf_o
);

  localparam int MSB = NUM_BITS - 1;

  assign sum_o = a_i + b_i;

  // Same-sign operands whose sum flips sign overflowed.
  assign ovf_o = (a_i[MSB] == b_i[MSB]) &&
                 (sum_o[MSB] != a_i[MSB]);

endmodule

// File: rtl/acumulador.sv
// Signed beat accumulator with start/count control and flags.
// Define ACUMULADOR_SATURATE_EN to clamp on overflow instead of wrapping.
module acumulador
  import acumulador_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input  logic         clock,
  input  logic         reset,
  acumulador_if.slave  bus
);

  localparam int MSB = NUM_BITS - 1;

  state_e                     state_q;
  logic signed [NUM_BITS-1:0] acc_q;
  logic signed [NUM_BITS-1:0] acc_d;
  logic [CNT_BITS-1:0]        rem_q;
  flags_t                     flags_q;
  flags_t                     flags_d;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       busy_q;

  logic signed [NUM_BITS-1:0] sum_w;
  logic                       ovf_w;
  logic                       beat_w;

  acc_somador #(
    .NUM_BITS (NUM_BITS)
  ) u_somador (
    .a_i   (acc_q),
    .b_i   (bus.in_data),
    .sum_o (sum_w),
    .ovf_o (ovf_w)
  );

`ifdef ACUMULADOR_SATURATE_EN
  localparam logic signed [NUM_BITS-1:0] MAX_POS =
    {1'b0, {(NUM_BITS-1){1'b1}}};
  localparam logic signed [NUM_BITS-1:0] MIN_NEG =
    {1'b1, {(NUM_BITS-1){1'b0}}};

  // Overflow direction follows the shared operand sign.
  always_comb begin
    acc_d = sum_w;
    if (ovf_w) begin
      acc_d = acc_q[MSB] ? MIN_NEG : MAX_POS;
    end
  end
`else
  assign acc_d = sum_w;
`endif

  always_comb begin
    flags_d   = flags_q;
    flags_d.Z = (acc_d == '0);
    flags_d.N = acc_d[MSB];
    flags_d.P = ~acc_d[0];
    flags_d.V = flags_q.V | ovf_w;
  end

  assign beat_w = bus.in_valid && in_ready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      flags_q     <= FLAGS_CLR;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q   <= '0;
            flags_q <= FLAGS_CLR;
            busy_q  <= 1'b1;
            if (bus.count != '0) begin
              rem_q      <= bus.count;
              in_ready_q <= 1'b1;
              state_q    <= ACCUM;
            end else begin
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (beat_w) begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
            rem_q   <= rem_q - CNT_BITS'(1);
            if (rem_q == CNT_BITS'(1)) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          // start is not looked at here, even on the handshake cycle.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = acc_q;
  assign bus.Z         = flags_q.Z;
  assign bus.N         = flags_q.N;
  assign bus.P         = flags_q.P;
  assign bus.V         = flags_q.V;

endmodule

// File: tb/tb_acumulador.sv
// Directed self-checking bench for acumulador.
// Expected values account for ACUMULADOR_SATURATE_EN when defined.
module tb_acumulador;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  acumulador_if #(.NUM_BITS(8), .CNT_BITS(4)) bus ();

  acumulador #(
    .NUM_BITS (8),
    .CNT_BITS (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_res(input string tag, input int s,
                         input logic z, input logic n,
                         input logic p, input logic v);
    chk({tag, ".S"}, bus.S, s);
    chk({tag, ".Z"}, bus.Z, z);
    chk({tag, ".N"}, bus.N, n);
    chk({tag, ".P"}, bus.P, p);
    chk({tag, ".V"}, bus.V, v);
  endtask

  task automatic beat(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(d);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, ".ov_lo"}, bus.out_valid, 1'b0);
    chk({tag, ".idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.count     = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Asynchronous reset between clock edges
    #3 reset = 1'b1;
    #1;
    chk_res("rst", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.ov", bus.out_valid, 1'b0);
    chk("rst.ir", bus.in_ready, 1'b0);
    step();
    reset = 1'b0;
    step();

    // 5 + -2 + 4 = 7
    bus.start = 1'b1;
    bus.count = 4'd3;
    step();
    bus.start = 1'b0;
    chk("r1.busy", bus.busy, 1'b1);
    chk("r1.ir", bus.in_ready, 1'b1);
    beat(5);
    beat(-2);
    chk("r1.ov_early", bus.out_valid, 1'b0);
    beat(4);
    chk("r1.ov", bus.out_valid, 1'b1);
    chk("r1.ir_lo", bus.in_ready, 1'b0);
    chk_res("r1", 7, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("r1");

    // 100 + 100 overflows
    bus.start = 1'b1;
    bus.count = 4'd2;
    step();
    bus.start = 1'b0;
    beat(100);
    beat(100);
    chk("r2.ov", bus.out_valid, 1'b1);
`ifdef ACUMULADOR_SATURATE_EN
    chk_res("r2", 127, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    chk_res("r2", -56, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
    handshake("r2");

    // Sticky V: 100 + 100 - 50
    bus.start = 1'b1;
    bus.count = 4'd3;
    step();
    bus.start = 1'b0;
    chk("r2b.vclr", bus.V, 1'b0);
    beat(100);
    beat(100);
    beat(-50);
`ifdef ACUMULADOR_SATURATE_EN
    chk_res("r2b", 77, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    chk_res("r2b", -106, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
    handshake("r2b");

    // Negative overflow: -100 + -100
    bus.start = 1'b1;
    bus.count = 4'd2;
    step();
    bus.start = 1'b0;
    beat(-100);
    beat(-100);
`ifdef ACUMULADOR_SATURATE_EN
    chk_res("r2c", -128, 1'b0, 1'b1, 1'b1, 1'b1);
`else
    chk_res("r2c", 56, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    handshake("r2c");

    // count = 0 goes straight to DONE
    bus.start = 1'b1;
    bus.count = 4'd0;
    chk("r3.ir_pre", bus.in_ready, 1'b0);
    step();
    bus.start = 1'b0;
    chk("r3.ov", bus.out_valid, 1'b1);
    chk("r3.ir", bus.in_ready, 1'b0);
    chk_res("r3", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    handshake("r3");

    // Gaps in ACCUM, stalled DONE with start pulsed
    bus.start = 1'b1;
    bus.count = 4'd2;
    step();
    bus.start = 1'b0;
    beat(10);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r4.gap_ir", bus.in_ready, 1'b1);
      chk("r4.gap_ov", bus.out_valid, 1'b0);
      chk("r4.gap_S", bus.S, 10);
    end
    beat(20);
    chk("r4.ov", bus.out_valid, 1'b1);
    chk_res("r4", 30, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.count = 4'd1;
    for (int i = 0; i < 5; i++) begin
      bus.start = (i % 2 == 0);
      step();
      chk("r4.hold_ov", bus.out_valid, 1'b1);
      chk("r4.hold_S", bus.S, 30);
      chk("r4.hold_busy", bus.busy, 1'b1);
    end
    bus.start = 1'b1;
    handshake("r4");
    bus.start = 1'b0;
    step();
    chk("r4.no_restart", bus.busy, 1'b0);
    chk("r4.no_ir", bus.in_ready, 1'b0);

    // Reset mid-run abandons it
    bus.start = 1'b1;
    bus.count = 4'd3;
    step();
    bus.start = 1'b0;
    beat(7);
    chk("r5.mid_S", bus.S, 7);
    #2 reset = 1'b1;
    #1;
    chk("r5.busy", bus.busy, 1'b0);
    chk("r5.ir", bus.in_ready, 1'b0);
    chk_res("r5.rst", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk("r5.ov", bus.out_valid, 1'b0);
    chk("r5.idle", bus.busy, 1'b0);

    // Fresh run: single beat -3
    bus.start = 1'b1;
    bus.count = 4'd1;
    step();
    bus.start = 1'b0;
    beat(-3);
    chk("r6.ov", bus.out_valid, 1'b1);
    chk_res("r6", -3, 1'b0, 1'b1, 1'b0, 1'b0);
    handshake("r6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
